serial_rx: RTL and testbench

Receiving end of the bread-board two-wire serial link (`sck` clock, `sda` data). It samples the link on the FPGA system clock and detects start and stop conditions. It deserialises MSB-first bytes, presenting each byte with a one-cycle valid strobe. It sits beside the transmit-side control logic so a board can loop back or listen to the same lines the logic analyser probes.

---
 rtl/serial_rx.sv | 131 +++++++++++++
 tb/tb_serial_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Two-wire (sck/sda) serial receiver: synchronises the link, detects start/stop
// conditions and deserialises MSB-first words with a one-cycle valid strobe.
module serial_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              sda,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              busy,
   output logic              frame_err,
   output logic [7:0]        byte_cnt
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE, RECV} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, sda_sync_q;
   logic                   sck_q, sda_q;
   logic                   sck_s, sda_s;
   logic                   rise, start, stop;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_W-2:0]      shift_q, shift_d;
   logic [DATA_W-1:0]      word;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [7:0]             byte_cnt_q, byte_cnt_d;

   // Synchronisers reset high so a released reset never fakes an event on an idle bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q <= '1;
         sda_sync_q <= '1;
         sck_q      <= 1'b1;
         sda_q      <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
         sck_q      <= sck_s;
         sda_q      <= sda_s;
      end
   end

   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   assign rise  = sck_s & ~sck_q;
   assign start = sck_s & sck_q & ~sda_s & sda_q;
   assign stop  = sck_s & sck_q & sda_s & ~sda_q;

   // Only DATA_W-1 bits are ever held; the final bit joins them straight into data.
   assign word = {shift_q, sda_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RECV;
         RECV:    if (stop)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      byte_cnt_d  = byte_cnt_q;
      if (state_q == IDLE) begin
         if (start) begin
            bit_cnt_d  = '0;
            shift_d    = '0;
            byte_cnt_d = '0;
         end
      end else if (rise) begin
         shift_d = word[DATA_W-2:0];
         if (bit_cnt_q == LAST_BIT) begin
            data_d     = word;
            valid_d    = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end else if (stop) begin
         frame_err_d = (bit_cnt_q != '0);
      end else if (start) begin
         // Repeated start: a partial word is abandoned and the frame restarts.
         frame_err_d = (bit_cnt_q != '0);
         bit_cnt_d   = '0;
         shift_d     = '0;
         byte_cnt_d  = '0;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign byte_cnt  = byte_cnt_q;
   assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_serial_rx.sv
// Randomised scoreboard bench for serial_rx: a line-level driver feeds a
// word/frame reference model whose expected pulses a monitor pops and compares.
module tb_serial_rx;

   localparam int DW = 8;
   localparam int P  = 8;   // sck phase length in clk cycles
   localparam int H  = 4;   // half of the low phase, where sda may change

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sck = 1'b1;
   logic          sda = 1'b1;
   logic [DW-1:0] data;
   logic          valid;
   logic          busy;
   logic          frame_err;
   logic [7:0]    byte_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      logic [7:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model state: frame open flag, pending bits, last word, word count.
   bit         m_open = 1'b0;
   bit         m_bits[$];
   logic [7:0] m_data = 8'h00;
   logic [7:0] m_cnt  = 8'h00;

   serial_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sck       (sck),
      .sda       (sda),
      .data      (data),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err),
      .byte_cnt  (byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (valid || frame_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%b frame_err=%b data=%h expected no pulse at %0t",
                     valid, frame_err, data, $time);
         end else begin
            mon_e = exp_q.pop_front();
            $display("rx %s data=%h byte_cnt=%0d", frame_err ? "frame_err" : "word", data, byte_cnt);
            chk("pulse_frame_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
            chk("pulse_valid", {31'd0, valid}, {31'd0, !mon_e.is_err});
            chk("pulse_data", {24'd0, data}, {24'd0, mon_e.data});
            chk("pulse_byte_cnt", {24'd0, byte_cnt}, {24'd0, mon_e.cnt});
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic m_rise(input bit b);
      logic [7:0] w;
      if (m_open) begin
         m_bits.push_back(b);
         if (m_bits.size() == DW) begin
            w = '0;
            for (int i = 0; i < DW; i++) w[DW-1-i] = m_bits[i];
            m_bits.delete();
            m_data = w;
            m_cnt  = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
            exp_q.push_back('{is_err: 1'b0, data: m_data, cnt: m_cnt});
         end
      end
   endtask

   task automatic m_start();
      if (m_open && m_bits.size() != 0)
         exp_q.push_back('{is_err: 1'b1, data: m_data, cnt: 8'd0});
      m_open = 1'b1;
      m_bits.delete();
      m_cnt = 8'd0;
   endtask

   task automatic m_stop();
      if (m_open) begin
         if (m_bits.size() != 0)
            exp_q.push_back('{is_err: 1'b1, data: m_data, cnt: m_cnt});
         m_open = 1'b0;
         m_bits.delete();
      end
   endtask

   // ---------------- line driver (sck is high between primitives) ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit b);
      sck = 1'b0;
      wait_clk(H);
      sda = b;
      wait_clk(H);
      sck = 1'b1;
      m_rise(b);
      wait_clk(P);
   endtask

   task automatic bus_start();
      if (sda == 1'b0) drive_bit(1'b1);
      sda = 1'b0;
      m_start();
      wait_clk(P);
   endtask

   task automatic bus_stop();
      if (sda == 1'b1) drive_bit(1'b0);
      sda = 1'b1;
      m_stop();
      wait_clk(P);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = DW - 1; i >= 0; i--) drive_bit(b[i]);
   endtask

   task automatic check_quiet(input string tag);
      wait_clk(4);
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, m_open});
      chk({tag, "_byte_cnt"}, {24'd0, byte_cnt}, {24'd0, m_cnt});
      chk({tag, "_data"}, {24'd0, data}, {24'd0, m_data});
      chk({tag, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      sck = 1'b1;
      sda = 1'b1;
      wait_clk(1);
      chk("rst_data", {24'd0, data}, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_frame_err", {31'd0, frame_err}, 0);
      chk("rst_byte_cnt", {24'd0, byte_cnt}, 0);
      wait_clk(cycles);
      m_open = 1'b0;
      m_bits.delete();
      m_cnt  = 8'd0;
      m_data = 8'd0;
      exp_q.delete();
      rst = 1'b0;
   endtask

   initial begin
      do_reset(5);
      wait_clk(20);
      check_quiet("idle");

      bus_start();
      chk("busy_after_start", {31'd0, busy}, 1);
      send_byte(8'hA5);
      bus_stop();
      check_quiet("a5");

      bus_start();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      bus_stop();
      check_quiet("three");
      wait_clk(20);
      check_quiet("three_held");

      bus_start();
      for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)));
      bus_stop();
      check_quiet("partial");

      bus_start();
      for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)));
      bus_start();
      send_byte(8'h81);
      bus_stop();
      check_quiet("rep_start");

      for (int f = 0; f < 30; f++) begin
         bus_start();
         for (int b = 0; b < int'($urandom_range(0, 3)); b++) send_byte(8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) drive_bit(1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 3) == 0) begin
            bus_start();
            send_byte(8'($urandom));
         end
         bus_stop();
         check_quiet("rand");
      end

      bus_start();
      for (int b = 0; b < 300; b++) send_byte(8'h55);
      check_quiet("saturate");
      bus_stop();
      check_quiet("saturate_stop");

      bus_start();
      send_byte(8'hC3);
      for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)));
      do_reset(3);
      wait_clk(10);
      check_quiet("post_reset");
      bus_start();
      send_byte(8'h5A);
      bus_stop();
      check_quiet("after_reset_frame");

      wait_clk(10);
      chk("final_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
